// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of the async FIFO bridge: two requesters, storage write port,
// and the pointer exchange with the read-side synchronizer.
interface fifo_wr_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic [AW:0]   rd_ptr_gray_sync;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [1:0]    owner;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rd_ptr_gray_sync,
    input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, wr_ptr_gray, full, owner
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rd_ptr_gray_sync,
    output req0_ready, req1_ready, wr_en, wr_addr, wr_data, wr_ptr_gray, full, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port; owns the binary/Gray
// write pointer and derives full against the synchronized read pointer.
module fifo_wr_arbiter #(
  parameter int AW    = 3,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW:0]   bin, gray, bin_nxt;
  logic          full, acc, own1, vx, vo, rdyx, rdy0, rdy1;
  logic [DW-1:0] wdata;

  // Full when the pointers match except for the two MSBs (Gray wrap distance).
  assign full    = (gray == {~bus.rd_ptr_gray_sync[AW:AW-1], bus.rd_ptr_gray_sync[AW-2:0]});
  assign bin_nxt = bin + 1'b1;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    own1      = (state == OWN1);
    vx        = own1 ? bus.req1_valid : bus.req0_valid;
    vo        = own1 ? bus.req0_valid : bus.req1_valid;
    rdyx      = 1'b0;
    acc       = 1'b0;
    wdata     = own1 ? bus.req1_data : bus.req0_data;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.req0_valid && (!bus.req1_valid || last)) state_nxt = OWN0;
        else if (bus.req1_valid)                        state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        rdyx = !full && !reset;
        acc  = vx && rdyx;
        // While full everything is frozen: no count, no release.
        if (!full) begin
          if (acc) cnt_nxt = cnt + 1'b1;
          if (!vx || (acc && cnt_nxt == CW'(BURST))) begin
            last_nxt = own1;
            cnt_nxt  = '0;
            if (vo)      state_nxt = own1 ? OWN0 : OWN1;
            else if (vx) state_nxt = state;
            else         state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdy0 = rdyx && !own1;
  assign rdy1 = rdyx && own1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      bin   <= '0;
      gray  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (acc) begin
        bin  <= bin_nxt;
        gray <= bin_nxt ^ (bin_nxt >> 1);
      end
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.wr_en       = acc;
  assign bus.wr_addr     = bin[AW-1:0];
  assign bus.wr_data     = wdata;
  assign bus.wr_ptr_gray = gray;
  assign bus.full        = full;
  assign bus.owner       = state;
endmodule
